// File: rtl/video_rx_st.sv
// Parallel video receiver: registers DE/HSYNC/VSYNC/RGB and repacks each whole,
// VSYNC-locked active frame into one Avalon-ST packet with geometry checking.
module video_rx_st #(
    parameter int DATA_WIDTH      = 32,
    parameter int HACTIVE         = 1280,
    parameter int VACTIVE         = 720,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  vid_de_i,
    input  logic                  vid_hsync_i,
    input  logic                  vid_vsync_i,
    input  logic [7:0]            vid_r_i,
    input  logic [7:0]            vid_g_i,
    input  logic [7:0]            vid_b_i,
    output logic                  aso_src_valid_o,
    output logic [DATA_WIDTH-1:0] aso_src_data_o,
    output logic                  aso_src_startofpacket_o,
    output logic                  aso_src_endofpacket_o,
    output logic                  frame_start_o,
    output logic                  frame_error_o,
    output logic [15:0]           frame_count_o
);

    localparam int PW = $clog2(HACTIVE + 1);
    localparam int LW = $clog2(VACTIVE + 1);
    localparam logic [PW-1:0] P_HMAX  = PW'(HACTIVE);
    localparam logic [PW-1:0] P_HLAST = PW'(HACTIVE - 1);
    localparam logic [LW-1:0] P_VLAST = LW'(VACTIVE - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, FRAME} state_t;

    state_t          r_state;
    logic            r_de1, r_hs1, r_vs1;
    logic [23:0]     r_rgb1;
    logic            r_de_prev, r_vsact_prev;
    logic [PW-1:0]   r_pix;
    logic [LW-1:0]   r_line;
    logic            r_long;
    logic [15:0]     r_fcnt;
    logic            r_fv, r_fsop, r_feop, r_fstart, r_ferr;
    logic [DATA_WIDTH-1:0] r_fdata;
    logic            r_valid, r_sop, r_eop, r_start, r_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]     r_count;

    logic w_vs_act, w_vs_edge, w_de_fall, w_unused_hsync;

    assign w_vs_act       = r_vs1 ^ SYNC_ACTIVE_LOW;
    assign w_vs_edge      = w_vs_act & ~r_vsact_prev;
    assign w_de_fall      = r_de_prev & ~r_de1;
    assign w_unused_hsync = r_hs1;

    // Sync registers reset to their deasserted level so release never looks like a VSYNC edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de1        <= 1'b0;
            r_hs1        <= SYNC_ACTIVE_LOW;
            r_vs1        <= SYNC_ACTIVE_LOW;
            r_rgb1       <= '0;
            r_de_prev    <= 1'b0;
            r_vsact_prev <= 1'b0;
        end else begin
            r_de1        <= vid_de_i;
            r_hs1        <= vid_hsync_i;
            r_vs1        <= vid_vsync_i;
            r_rgb1       <= {vid_b_i, vid_g_i, vid_r_i};
            r_de_prev    <= r_de1;
            r_vsact_prev <= w_vs_act;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pix    <= '0;
            r_line   <= '0;
            r_long   <= 1'b0;
            r_fcnt   <= '0;
            r_fv     <= 1'b0;
            r_fsop   <= 1'b0;
            r_feop   <= 1'b0;
            r_fstart <= 1'b0;
            r_ferr   <= 1'b0;
            r_fdata  <= '0;
        end else begin
            r_fv     <= 1'b0;
            r_fsop   <= 1'b0;
            r_feop   <= 1'b0;
            r_fstart <= 1'b0;
            r_ferr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i) r_state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (w_vs_edge) begin
                        r_fstart <= 1'b1;
                        r_pix    <= '0;
                        r_line   <= '0;
                        r_long   <= 1'b0;
                        r_state  <= FRAME;
                    end
                end
                FRAME: begin
                    // VSYNC wins over a coincident pixel; an edge here is always premature.
                    if (w_vs_edge) begin
                        r_ferr   <= 1'b1;
                        r_fstart <= 1'b1;
                        r_pix    <= '0;
                        r_line   <= '0;
                        r_long   <= 1'b0;
                    end else if (r_de1) begin
                        if (r_pix < P_HMAX) begin
                            r_fv    <= 1'b1;
                            r_fdata <= DATA_WIDTH'(r_rgb1);
                            r_fsop  <= (r_pix == '0) && (r_line == '0);
                            r_pix   <= r_pix + PW'(1);
                            if (r_pix == P_HLAST && r_line == P_VLAST) begin
                                r_feop  <= 1'b1;
                                r_fcnt  <= r_fcnt + 16'd1;
                                r_state <= enable_i ? WAIT_VS : IDLE;
                            end
                        end else begin
                            r_long <= 1'b1;
                        end
                    end else if (w_de_fall) begin
                        r_line <= r_line + LW'(1);
                        r_pix  <= '0;
                        r_long <= 1'b0;
                        if (r_line == P_VLAST) begin
                            r_ferr  <= 1'b1;
                            r_state <= enable_i ? WAIT_VS : IDLE;
                        end else if (r_pix != P_HMAX || r_long) begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_valid <= r_fv;
            r_sop   <= r_fsop;
            r_eop   <= r_feop;
            r_start <= r_fstart;
            r_err   <= r_ferr;
            r_data  <= r_fdata;
            r_count <= r_fcnt;
        end
    end

    assign aso_src_valid_o         = r_valid;
    assign aso_src_data_o          = r_data;
    assign aso_src_startofpacket_o = r_sop;
    assign aso_src_endofpacket_o   = r_eop;
    assign frame_start_o           = r_start;
    assign frame_error_o           = r_err;
    assign frame_count_o           = r_count;

endmodule
